// File: rtl/control_sequencer.sv
// control_sequencer: microcode sequencer for the 8-bit single-bus computer.
// Steps a one-hot T1..T6 ring, decodes the IR opcode and drives every
// register's write-enable / output-enable line combinationally.
// Optional build macro SEQ_SKIP_IDLE_EN: when defined, instructions whose
// work finishes early return to T1 instead of idling through the unused
// T-states.
module control_sequencer #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned T_STATES = 6
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [OPCODE_W-1:0] Opcode,
  output logic                PC_OE,
  output logic                PC_INC,
  output logic                MAR_WE,
  output logic                RAM_OE,
  output logic                IR_WE,
  output logic                IR_OE,
  output logic                Acc_WE,
  output logic                Acc_OE,
  output logic                B_WE,
  output logic                ALU_OE,
  output logic                SUB,
  output logic                Out_WE,
  output logic                HALT,
  output logic [T_STATES-1:0] T_state
);

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'b0000);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0001);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0010);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'b1110);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'b1111);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e ring, ring_next;
  logic     halted, halted_next;

  logic is_lda, is_add, is_sub, is_out, is_hlt;

  // Opcode class decode
  always_comb begin
    is_lda = (Opcode == OP_LDA);
    is_add = (Opcode == OP_ADD);
    is_sub = (Opcode == OP_SUB);
    is_out = (Opcode == OP_OUT);
    is_hlt = (Opcode == OP_HLT);
  end

`ifdef SEQ_SKIP_IDLE_EN
  logic is_nop;

  // Anything outside the decoded set behaves as a no-operation
  always_comb begin
    is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);
  end
`endif

  // Ring position and halt flag; reset returns to T1 and clears halt
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ring   <= T1;
      halted <= 1'b0;
    end else begin
      ring   <= ring_next;
      halted <= halted_next;
    end
  end

  // Next ring position: advance once per edge, frozen while halted
  always_comb begin
    ring_next   = ring;
    halted_next = halted;
    if (!halted) begin
      unique case (ring)
        T1:      ring_next = T2;
        T2:      ring_next = T3;
        T3:      ring_next = T4;
        T4:      ring_next = T5;
        T5:      ring_next = T6;
        T6:      ring_next = T1;
        default: ring_next = T1;
      endcase
      if (ring == T4 && is_hlt) begin
        halted_next = 1'b1;
      end
`ifdef SEQ_SKIP_IDLE_EN
      if (ring == T4 && is_nop) begin
        ring_next = T1;
      end
      if (ring == T5 && (is_lda || is_out)) begin
        ring_next = T1;
      end
`endif
    end
  end

  // Control decode; everything held low during reset or once halted
  always_comb begin
    PC_OE  = 1'b0;
    PC_INC = 1'b0;
    MAR_WE = 1'b0;
    RAM_OE = 1'b0;
    IR_WE  = 1'b0;
    IR_OE  = 1'b0;
    Acc_WE = 1'b0;
    Acc_OE = 1'b0;
    B_WE   = 1'b0;
    ALU_OE = 1'b0;
    SUB    = 1'b0;
    Out_WE = 1'b0;
    if (!RESET && !halted) begin
      unique case (ring)
        T1: begin
          PC_OE  = 1'b1;
          MAR_WE = 1'b1;
        end
        T2: begin
          PC_INC = 1'b1;
        end
        T3: begin
          RAM_OE = 1'b1;
          IR_WE  = 1'b1;
        end
        T4: begin
          if (is_lda || is_add || is_sub) begin
            IR_OE  = 1'b1;
            MAR_WE = 1'b1;
          end
          // Accumulator output is registered, so OE is raised a cycle early
          if (is_out) begin
            Acc_OE = 1'b1;
          end
          SUB = is_sub;
        end
        T5: begin
          if (is_lda) begin
            RAM_OE = 1'b1;
            Acc_WE = 1'b1;
          end
          if (is_add || is_sub) begin
            RAM_OE = 1'b1;
            B_WE   = 1'b1;
          end
          if (is_out) begin
            Acc_OE = 1'b1;
            Out_WE = 1'b1;
          end
          SUB = is_sub;
        end
        T6: begin
          if (is_add || is_sub) begin
            ALU_OE = 1'b1;
            Acc_WE = 1'b1;
          end
          SUB = is_sub;
        end
        default: ;
      endcase
    end
  end

  assign HALT    = halted;
  assign T_state = T_STATES'(ring);

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: self-checking bench for control_sequencer using a
// table-level reference of each instruction's per-cycle control word.
module tb_control_sequencer;

  logic       CLK;
  logic       RESET;
  logic [3:0] Opcode;
  logic PC_OE, PC_INC, MAR_WE, RAM_OE, IR_WE, IR_OE;
  logic Acc_WE, Acc_OE, B_WE, ALU_OE, SUB, Out_WE, HALT;
  logic [5:0] T_state;

  int checks = 0;
  int errors = 0;

  // Control word bit positions
  localparam logic [11:0] C_PC_OE  = 12'h800;
  localparam logic [11:0] C_PC_INC = 12'h400;
  localparam logic [11:0] C_MAR_WE = 12'h200;
  localparam logic [11:0] C_RAM_OE = 12'h100;
  localparam logic [11:0] C_IR_WE  = 12'h080;
  localparam logic [11:0] C_IR_OE  = 12'h040;
  localparam logic [11:0] C_ACC_WE = 12'h020;
  localparam logic [11:0] C_ACC_OE = 12'h010;
  localparam logic [11:0] C_B_WE   = 12'h008;
  localparam logic [11:0] C_ALU_OE = 12'h004;
  localparam logic [11:0] C_SUB    = 12'h002;
  localparam logic [11:0] C_OUT_WE = 12'h001;

  logic [11:0] ctl;
  assign ctl = {PC_OE, PC_INC, MAR_WE, RAM_OE, IR_WE, IR_OE,
                Acc_WE, Acc_OE, B_WE, ALU_OE, SUB, Out_WE};

  control_sequencer dut (
    .CLK(CLK), .RESET(RESET), .Opcode(Opcode),
    .PC_OE(PC_OE), .PC_INC(PC_INC), .MAR_WE(MAR_WE), .RAM_OE(RAM_OE),
    .IR_WE(IR_WE), .IR_OE(IR_OE), .Acc_WE(Acc_WE), .Acc_OE(Acc_OE),
    .B_WE(B_WE), .ALU_OE(ALU_OE), .SUB(SUB), .Out_WE(Out_WE),
    .HALT(HALT), .T_state(T_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Small datapath model: accumulator with registered OE feeding the output register
  logic [7:0] acc_val;
  logic       acc_drv;
  logic [7:0] out_reg;
  always @(posedge CLK) begin
    if (Out_WE && acc_drv) out_reg <= acc_val;
    acc_drv <= Acc_OE;
  end

  // Expected control word for step k (0 = T1) of an instruction
  function automatic logic [11:0] exp_ctl(input logic [3:0] op, input int k);
    logic [11:0] w;
    logic        arith;
    arith = (op == 4'b0001) || (op == 4'b0010);
    w = 12'h000;
    case (k)
      0: w = C_PC_OE | C_MAR_WE;
      1: w = C_PC_INC;
      2: w = C_RAM_OE | C_IR_WE;
      3: begin
        if (op == 4'b0000 || arith) w = C_IR_OE | C_MAR_WE;
        if (op == 4'b1110) w = C_ACC_OE;
      end
      4: begin
        if (op == 4'b0000) w = C_RAM_OE | C_ACC_WE;
        if (arith) w = C_RAM_OE | C_B_WE;
        if (op == 4'b1110) w = C_ACC_OE | C_OUT_WE;
      end
      5: if (arith) w = C_ALU_OE | C_ACC_WE;
      default: w = 12'h000;
    endcase
    if (op == 4'b0010 && k >= 3) w = w | C_SUB;
    return w;
  endfunction

  // Cycles an instruction occupies before the ring is back at T1
  function automatic int instr_len(input logic [3:0] op);
`ifdef SEQ_SKIP_IDLE_EN
    if (op == 4'b0000 || op == 4'b1110) return 5;
    if (op == 4'b0001 || op == 4'b0010) return 6;
    return 4;
`else
    if (op == 4'b1111) return 6;
    return 6;
`endif
  endfunction

  // Run one non-halting instruction from T1, checking every cycle
  task automatic run_instr(input logic [3:0] op);
    int drivers;
    Opcode = op;
    for (int k = 0; k < instr_len(op); k++) begin
      checks++;
      if (ctl !== exp_ctl(op, k)) begin
        errors++;
        $display("FAIL ctl op=%b step=%0d got=%h exp=%h", op, k, ctl, exp_ctl(op, k));
      end
      checks++;
      if (T_state !== 6'(1 << k)) begin
        errors++;
        $display("FAIL t_state op=%b step=%0d got=%b exp=%b", op, k, T_state, 6'(1 << k));
      end
      drivers = int'(PC_OE) + int'(RAM_OE) + int'(IR_OE) + int'(ALU_OE) + int'(Acc_OE);
      checks++;
      if (drivers > 1 || (Acc_OE && Acc_WE) || HALT !== 1'b0) begin
        errors++;
        $display("FAIL bus op=%b step=%0d drivers=%0d acc_we=%b acc_oe=%b halt=%b",
                 op, k, drivers, Acc_WE, Acc_OE, HALT);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    Opcode = 4'h0;
    acc_val = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (T_state !== 6'b000001 || ctl !== 12'h000 || HALT !== 1'b0) begin
      errors++;
      $display("FAIL reset_state t=%b ctl=%h halt=%b exp t=000001 ctl=000 halt=0", T_state, ctl, HALT);
    end
    @(negedge CLK); RESET = 1'b0; #1;
  endtask

  task automatic test_reset_mid_fetch;
    run_instr(4'h3);
    @(posedge CLK); #1;
    checks++;
    if (T_state !== 6'b000010) begin
      errors++;
      $display("FAIL mid_fetch_t2 got=%b exp=000010", T_state);
    end
    RESET = 1'b1; #1;
    checks++;
    if (T_state !== 6'b000001 || ctl !== 12'h000) begin
      errors++;
      $display("FAIL mid_fetch_reset t=%b ctl=%h exp t=000001 ctl=000", T_state, ctl);
    end
    @(posedge CLK); #1;
    checks++;
    if (T_state !== 6'b000001 || ctl !== 12'h000) begin
      errors++;
      $display("FAIL mid_fetch_hold t=%b ctl=%h exp t=000001 ctl=000", T_state, ctl);
    end
    @(negedge CLK); RESET = 1'b0; #1;
    checks++;
    if (ctl !== (C_PC_OE | C_MAR_WE)) begin
      errors++;
      $display("FAIL mid_fetch_t1 ctl=%h exp=%h", ctl, C_PC_OE | C_MAR_WE);
    end
    run_instr(4'h0);
  endtask

  task automatic test_lda;
    run_instr(4'b0000);
    checks++;
    if (T_state !== 6'b000001) begin
      errors++;
      $display("FAIL lda_wrap got=%b exp=000001", T_state);
    end
  endtask

  task automatic test_sub;
    run_instr(4'b0010);
    run_instr(4'b0001);
  endtask

  task automatic test_out;
    acc_val = 8'h5A;
    out_reg = 8'h00;
    run_instr(4'b1110);
    checks++;
    if (out_reg !== 8'h5A) begin
      errors++;
      $display("FAIL out_capture got=%h exp=5a", out_reg);
    end
  endtask

  task automatic test_lengths;
    logic [3:0] ops [2];
    int n;
    ops[0] = 4'b0000;
    ops[1] = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      Opcode = ops[i];
      n = 0;
      do begin
        @(posedge CLK); #1;
        n++;
      end while (T_state !== 6'b000001 && n < 12);
      checks++;
      if (n !== instr_len(ops[i])) begin
        errors++;
        $display("FAIL length op=%b got=%0d exp=%0d", ops[i], n, instr_len(ops[i]));
      end
    end
  endtask

  task automatic test_hlt;
    Opcode = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ctl !== exp_ctl(4'b1111, k) || HALT !== 1'b0) begin
        errors++;
        $display("FAIL hlt_pre step=%0d ctl=%h halt=%b exp ctl=%h halt=0",
                 k, ctl, HALT, exp_ctl(4'b1111, k));
      end
      @(posedge CLK); #1;
    end
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (HALT !== 1'b1 || T_state !== 6'b010000 || ctl !== 12'h000) begin
        errors++;
        $display("FAIL hlt_frozen cyc=%0d halt=%b t=%b ctl=%h exp halt=1 t=010000 ctl=000",
                 c, HALT, T_state, ctl);
      end
      Opcode = 4'($urandom_range(0, 15));
      @(posedge CLK); #1;
    end
    @(negedge CLK); RESET = 1'b1; #1;
    checks++;
    if (HALT !== 1'b0 || T_state !== 6'b000001) begin
      errors++;
      $display("FAIL hlt_reset halt=%b t=%b exp halt=0 t=000001", HALT, T_state);
    end
    @(negedge CLK); RESET = 1'b0; #1;
    run_instr(4'b0000);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 200; i++) begin
      run_instr(4'($urandom_range(0, 14)));
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_sub();
    test_out();
    test_reset_mid_fetch();
    test_lengths();
    test_back_to_back();
    test_hlt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
